codec_config_sequencer: RTL and testbench
=========================================

Name: codec_config_sequencer

Overview:
- Walks a fixed table of 16-bit audio-codec register words: codec device address 0x34 with 7-bit register address + 9-bit data per word.
- Hands each word in turn to the I2C write engine. Gates the engine's ignition, waits for transaction completion, checks the three ACK bits, retries on NACK or timeout, and spaces transactions with an idle gap.
- Sits between top-level bring-up logic and the I2C engine. Reports busy/done/error and current table index.

Parameters:
- NUM_WORDS, 11, number of table entries sent (1..16)
- MAX_RETRIES, 3, extra attempts per word after first failure (0..7)
- GAP_CYCLES, 5000, clk cycles of ignition-low idle between transactions (>=2)
- TIMEOUT_CYCLES, 1000000, clk cycles allowed per attempt before declaring timeout (>=16)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request configuration run; sampled in IDLE, DONE, FAIL
- i2c_finish  input  1  engine finish flag; high after last bit of a transaction
- i2c_ack  input  3  engine ACK bits [address, byte1, byte2]; 1 = acknowledged
- i2c_data  output  16  word presented to engine; {reg_addr[6:0], data[8:0]}
- i2c_ignition  output  1  enables engine clock generation; high only while an attempt is running
- busy  output  1  high from accepted start until DONE or FAIL
- done  output  1  high in DONE, sticky until next start
- error  output  1  high in FAIL, sticky until next start
- word_index  output  4  index of word in flight; final index held in DONE/FAIL
- retry_count  output  3  failed attempts on current word

Behaviour:
- Reset (clk edge with reset=0, any state): state=IDLE, i2c_ignition=0, i2c_data=0x0000, busy=0, done=0, error=0, word_index=0, retry_count=0, internal counters=0, finish_prev=0. Reset mid-transaction drops ignition the next edge.
- Table, index 0..10: 0x1E00 (codec reset), 0x0017, 0x0217, 0x0479, 0x0679, 0x0810, 0x0A00, 0x0C00, 0x0E02, 0x1000, 0x1201 (activate). Indices >= NUM_WORDS are never sent.
- finish_rise = i2c_finish & ~finish_prev. finish_prev is registered every cycle.
- IDLE: start=1 -> LOAD. word_index=0, retry_count=0, busy=1, done=0, error=0.
- LOAD, 1 cycle: i2c_data=table[word_index]. Timer cleared. -> RUN. i2c_data is stable for the whole attempt; it changes only in LOAD.
- RUN: i2c_ignition=1, timer increments.
  - finish_rise -> CHECK; ignition=0 on that same edge.
  - timer == TIMEOUT_CYCLES-1 without finish_rise -> RETRY; ignition=0.
  - finish_rise and timeout on the same cycle: finish wins.
  - i2c_finish already high on RUN entry is not a rise and is ignored.
- CHECK, 1 cycle: i2c_ack == 3'b111 -> GAP with retry_count=0 and pass flag set. Otherwise -> RETRY.
- RETRY: retry_count == MAX_RETRIES -> FAIL. Else retry_count+1 -> GAP with pass flag clear.
- GAP: ignition=0, counts GAP_CYCLES cycles, then:
  - pass flag clear: -> LOAD, same word.
  - pass flag set, word_index == NUM_WORDS-1: -> DONE.
  - pass flag set, otherwise: word_index+1 -> LOAD.
- DONE: busy=0, done=1. start=1 -> LOAD with index/retries cleared, done=0.
- FAIL: busy=0, error=1, word_index holds the failing word. start=1 restarts as in DONE.
- start while busy is ignored.
- Counters are wide enough for their parameters. No wrap occurs inside a state.
- i2c_ignition is low in every state except RUN.

Test Plan:
- Engine model ACKs all (ack=111, finish rises 200 cycles after ignition), GAP_CYCLES=10, pulse start -> 11 transactions. i2c_data sequence is 0x1E00...0x1201 in order. done=1, error=0, busy=0, word_index=10, ignition low between every pair of transactions for >=10 cycles.
- Word 3 ack=101 on first attempt, 111 after -> 0x0479 sent twice, retry_count shows 1 then 0, run completes with done=1. 12 ignition pulses total.
- Word 5 always NACKs, MAX_RETRIES=3 -> exactly 4 attempts of 0x0810, then error=1, done=0, word_index=5, retry_count=3, ignition=0.
- Finish never rises, TIMEOUT_CYCLES=50 -> each attempt ignition high for exactly 50 cycles. FAIL after 4 attempts on word 0.
- Reset low for one edge during RUN of word 2 -> next cycle ignition=0, state IDLE, all outputs at reset values. A new start begins at 0x1E00.
- start held high continuously through a run, and start pulsed during GAP -> no restart while busy. Restart only from DONE/FAIL.

Source files
------------

// File: rtl/codec_config_sequencer.sv
// -----------------------------------------------------------------------------
// codec_config_sequencer
//
// Purpose: walks a fixed table of 16-bit audio-codec register words (device
// address 0x34 is added by the I2C engine) and hands them one at a time to
// the I2C write engine. For each word it drives ignition for one attempt,
// waits for the engine's finish edge or a timeout, checks the three ACK bits,
// retries a bounded number of times, and leaves an ignition-low gap between
// attempts.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-low reset
//   start         request a configuration run (accepted in IDLE/DONE/FAIL)
//   i2c_finish    engine finish flag; only its rising edge ends an attempt
//   i2c_ack[2:0]  engine ACK bits {address, byte1, byte2}, 1 = acknowledged
//   i2c_data      word presented to the engine {reg_addr[6:0], data[8:0]}
//   i2c_ignition  engine enable, high only while an attempt is running
//   busy          run in progress
//   done          run completed, sticky until next start
//   error         run aborted after exhausting retries, sticky until next start
//   word_index    table index of the word in flight (held in DONE/FAIL)
//   retry_count   failed attempts on the current word
// -----------------------------------------------------------------------------
module codec_config_sequencer #(
   parameter int NUM_WORDS      = 11,
   parameter int MAX_RETRIES    = 3,
   parameter int GAP_CYCLES     = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        i2c_finish,
   input  logic [2:0]  i2c_ack,
   output logic [15:0] i2c_data,
   output logic        i2c_ignition,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  word_index,
   output logic [2:0]  retry_count
);

   // One timer serves both the per-attempt timeout and the inter-attempt gap,
   // so it is sized for the larger of the two.
   localparam int             TMAX         = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int             TW           = $clog2(TMAX);
   localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]  GAP_LAST     = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]  TIMER_ONE    = TW'(1);
   localparam logic [3:0]     LAST_WORD    = 4'(NUM_WORDS - 1);
   localparam logic [2:0]     RETRY_LIMIT  = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_CHECK, S_RETRY, S_GAP, S_DONE, S_FAIL
   } state_t;

   state_t         state, state_n;
   logic [TW-1:0]  timer, timer_n;
   logic           pass, pass_n;
   logic           finish_prev;
   logic           finish_rise;
   logic [15:0]    data_n;
   logic           busy_n, done_n, error_n;
   logic [3:0]     index_n;
   logic [2:0]     retry_n;

   // Codec bring-up table: reset first, activate last.
   function automatic logic [15:0] cfg_word(input logic [3:0] idx);
      case (idx)
         4'd0:    cfg_word = 16'h1E00;
         4'd1:    cfg_word = 16'h0017;
         4'd2:    cfg_word = 16'h0217;
         4'd3:    cfg_word = 16'h0479;
         4'd4:    cfg_word = 16'h0679;
         4'd5:    cfg_word = 16'h0810;
         4'd6:    cfg_word = 16'h0A00;
         4'd7:    cfg_word = 16'h0C00;
         4'd8:    cfg_word = 16'h0E02;
         4'd9:    cfg_word = 16'h1000;
         4'd10:   cfg_word = 16'h1201;
         default: cfg_word = 16'h0000;
      endcase
   endfunction

   // A finish level left high from a previous transaction is not a completion.
   assign finish_rise  = i2c_finish & ~finish_prev;
   assign i2c_ignition = (state == S_RUN);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         timer       <= '0;
         pass        <= 1'b0;
         finish_prev <= 1'b0;
         i2c_data    <= 16'h0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         word_index  <= 4'd0;
         retry_count <= 3'd0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         pass        <= pass_n;
         finish_prev <= i2c_finish;
         i2c_data    <= data_n;
         busy        <= busy_n;
         done        <= done_n;
         error       <= error_n;
         word_index  <= index_n;
         retry_count <= retry_n;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer;
      pass_n  = pass;
      data_n  = i2c_data;
      busy_n  = busy;
      done_n  = done;
      error_n = error;
      index_n = word_index;
      retry_n = retry_count;

      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_n = S_LOAD;
               index_n = 4'd0;
               retry_n = 3'd0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               error_n = 1'b0;
            end
         end
         // i2c_data only changes here, so it is stable for the whole attempt.
         S_LOAD: begin
            data_n  = cfg_word(word_index);
            timer_n = '0;
            state_n = S_RUN;
         end
         // Finish edge takes priority over a coincident timeout.
         S_RUN: begin
            if (finish_rise)
               state_n = S_CHECK;
            else if (timer == TIMEOUT_LAST)
               state_n = S_RETRY;
            else
               timer_n = timer + TIMER_ONE;
         end
         S_CHECK: begin
            timer_n = '0;
            if (i2c_ack == 3'b111) begin
               retry_n = 3'd0;
               pass_n  = 1'b1;
               state_n = S_GAP;
            end else begin
               state_n = S_RETRY;
            end
         end
         S_RETRY: begin
            timer_n = '0;
            if (retry_count == RETRY_LIMIT) begin
               state_n = S_FAIL;
               busy_n  = 1'b0;
               error_n = 1'b1;
            end else begin
               retry_n = retry_count + 3'd1;
               pass_n  = 1'b0;
               state_n = S_GAP;
            end
         end
         // Gap runs after every attempt; pass decides resend vs. advance.
         S_GAP: begin
            if (timer == GAP_LAST) begin
               if (!pass) begin
                  state_n = S_LOAD;
               end else if (word_index == LAST_WORD) begin
                  state_n = S_DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  index_n = word_index + 4'd1;
                  state_n = S_LOAD;
               end
            end else begin
               timer_n = timer + TIMER_ONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: reactive I2C engine model, a procedural
// reference model of the whole configuration run, a per-cycle compare, and
// literal checks on the recorded attempt stream.
module tb_codec_config_sequencer;
   localparam int NW  = 11;
   localparam int MR  = 3;
   localparam int GAP = 10;
   localparam int TO  = 250;

   logic        clk = 1'b0;
   logic        reset, start, i2c_finish;
   logic [2:0]  i2c_ack;
   logic [15:0] i2c_data;
   logic        i2c_ignition, busy, done, error;
   logic [3:0]  word_index;
   logic [2:0]  retry_count;

   codec_config_sequencer #(.NUM_WORDS(NW), .MAX_RETRIES(MR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .i2c_finish(i2c_finish), .i2c_ack(i2c_ack),
      .i2c_data(i2c_data), .i2c_ignition(i2c_ignition), .busy(busy), .done(done), .error(error),
      .word_index(word_index), .retry_count(retry_count));

   always #5 clk = ~clk;

   logic [15:0] tab [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0810,
                               16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

   int n_cmp = 0, n_fail = 0, n_print = 0;
   bit chk_en = 0;
   int mode = 0;

   // ---------------- reference model (post-edge expected outputs) ----------
   logic [15:0] e_data;
   logic        e_ign, e_busy, e_done, e_err;
   logic [3:0]  e_idx;
   logic [2:0]  e_rc;
   bit          s_start, s_fin, s_rst, m_fprev, m_rise, aborted;
   logic [2:0]  s_ack;

   task automatic set_reset_vals();
      e_data = 16'h0000; e_ign = 0; e_busy = 0; e_done = 0; e_err = 0; e_idx = 0; e_rc = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      s_start = start; s_fin = i2c_finish; s_ack = i2c_ack; s_rst = reset;
      m_rise  = s_fin && !m_fprev;
      m_fprev = s_rst ? s_fin : 1'b0;
      if (!s_rst) begin aborted = 1; set_reset_vals(); end
   endtask

   // One run from the edge that accepted start; returns on DONE, FAIL or reset.
   task automatic run_cfg();
      int w, n;
      bit pass, rise;
      e_busy = 1; e_done = 0; e_err = 0; e_idx = 0; e_rc = 0;
      w = 0;
      forever begin
         tick(); if (aborted) return;
         e_data = tab[w]; e_ign = 1;
         n = 0; rise = 0;
         forever begin
            tick(); if (aborted) return;
            n++;
            if (m_rise) begin rise = 1; break; end
            if (n == TO) break;
         end
         e_ign = 0;
         pass = 0;
         if (rise) begin
            tick(); if (aborted) return;
            pass = (s_ack == 3'b111);
            if (pass) e_rc = 0;
         end
         if (!pass) begin
            tick(); if (aborted) return;
            if (e_rc == MR) begin e_busy = 0; e_err = 1; return; end
            e_rc = e_rc + 3'd1;
         end
         for (int g = 0; g < GAP; g++) begin tick(); if (aborted) return; end
         if (pass) begin
            if (w == NW - 1) begin e_busy = 0; e_done = 1; return; end
            w++; e_idx = 4'(w);
         end
      end
   endtask

   initial begin
      set_reset_vals(); m_fprev = 0;
      forever begin
         aborted = 0;
         tick();
         if (!aborted && s_start) run_cfg();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         n_cmp++;
         if ({i2c_data, i2c_ignition, busy, done, error, word_index, retry_count} !==
             {e_data, e_ign, e_busy, e_done, e_err, e_idx, e_rc}) begin
            n_fail++;
            if (n_print < 30) begin
               n_print++;
               $display("FAIL cycle t=%0t: got data=%h ign=%b busy=%b done=%b err=%b idx=%0d rc=%0d, expected data=%h ign=%b busy=%b done=%b err=%b idx=%0d rc=%0d",
                        $time, i2c_data, i2c_ignition, busy, done, error, word_index, retry_count,
                        e_data, e_ign, e_busy, e_done, e_err, e_idx, e_rc);
            end
         end
      end
   end

   // ---------------- I2C engine model ----------------
   logic [15:0] pulse_data[$];
   int          pulse_len[$];
   int          eng_cnt, eng_delay, cur_len, low_cnt, min_gap;
   logic [2:0]  eng_ack;
   bit          ign_prev, stale, w3_done;

   initial begin
      i2c_finish = 0; i2c_ack = 3'b000; ign_prev = 0; stale = 0; low_cnt = 0; min_gap = 1000000;
      eng_cnt = 0; eng_delay = 0; cur_len = 0; eng_ack = 3'b111;
      forever begin
         @(negedge clk);
         if (i2c_ignition) begin
            if (!ign_prev) begin
               if (pulse_data.size() > 0 && low_cnt < min_gap) min_gap = low_cnt;
               pulse_data.push_back(i2c_data);
               eng_cnt = 0; cur_len = 0; i2c_ack = 3'b000; eng_ack = 3'b111;
               case (mode)
                  0: eng_delay = 200;
                  3: eng_delay = 0;
                  4: begin
                     case ($urandom_range(0, 9))
                        0: eng_delay = TO;
                        1: eng_delay = TO + 1;
                        2: eng_delay = 0;
                        default: eng_delay = $urandom_range(3, 240);
                     endcase
                     if ($urandom_range(0, 7) == 0) eng_ack = 3'($urandom_range(0, 6));
                  end
                  default: eng_delay = $urandom_range(3, 240);
               endcase
               if (mode == 1 && i2c_data == 16'h0479 && !w3_done) begin eng_ack = 3'b101; w3_done = 1; end
               if (mode == 2 && i2c_data == 16'h0810) eng_ack = 3'($urandom_range(0, 6));
            end
            eng_cnt++; cur_len++;
            if (eng_cnt == 2 && stale) begin i2c_finish = 0; stale = 0; end
            if (eng_cnt == eng_delay) begin i2c_finish = 1; i2c_ack = eng_ack; end
         end else begin
            if (ign_prev) begin
               pulse_len.push_back(cur_len); low_cnt = 0;
               stale = (mode == 4) && i2c_finish && ($urandom_range(0, 3) == 0);
               if (!stale) i2c_finish = 0;
            end
            low_cnt++;
         end
         ign_prev = i2c_ignition;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic lit(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_pulses();
      pulse_data.delete(); pulse_len.delete(); min_gap = 1000000; w3_done = 0;
   endtask

   task automatic pulse_start();
      start = 1; @(negedge clk); start = 0;
   endtask

   task automatic wait_end(input string nm);
      bit ok = 0;
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         if (!busy && (done || error)) begin ok = 1; start = 0; break; end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: run never ended, required done or error", nm);
      end
   endtask

   int cnt;
   bit hit;

   initial begin
      reset = 0; start = 0;
      @(negedge clk); @(negedge clk);
      chk_en = 1;
      lit("rst_ign", i2c_ignition, 0);
      lit("rst_data", i2c_data, 16'h0000);
      lit("rst_busy", busy, 0);
      reset = 1;

      // all ACK, finish 200 cycles into each attempt
      mode = 0; clear_pulses(); pulse_start(); wait_end("s0");
      lit("s0_pulses", pulse_data.size(), 11);
      for (int i = 0; i < 11 && i < pulse_data.size(); i++) lit($sformatf("s0_word%0d", i), pulse_data[i], tab[i]);
      lit("s0_first", pulse_data.size() > 0 ? pulse_data[0] : 0, 16'h1E00);
      lit("s0_last", pulse_data.size() > 10 ? pulse_data[10] : 0, 16'h1201);
      lit("s0_len", pulse_len.size() > 0 ? pulse_len[0] : 0, 200);
      lit("s0_gap_ge", min_gap >= GAP, 1);
      lit("s0_done", done, 1); lit("s0_error", error, 0); lit("s0_busy", busy, 0);
      lit("s0_idx", word_index, 10); lit("s0_ign", i2c_ignition, 0);

      // word 3 NACKed once
      mode = 1; clear_pulses(); pulse_start(); wait_end("s1");
      lit("s1_pulses", pulse_data.size(), 12);
      lit("s1_w3a", pulse_data.size() > 4 ? pulse_data[3] : 0, 16'h0479);
      lit("s1_w3b", pulse_data.size() > 4 ? pulse_data[4] : 0, 16'h0479);
      lit("s1_done", done, 1); lit("s1_rc", retry_count, 0);

      // word 5 always NACKs
      mode = 2; clear_pulses(); pulse_start(); wait_end("s2");
      cnt = 0;
      foreach (pulse_data[i]) if (pulse_data[i] == 16'h0810) cnt++;
      lit("s2_w5_attempts", cnt, 4);
      lit("s2_pulses", pulse_data.size(), 9);
      lit("s2_error", error, 1); lit("s2_done", done, 0);
      lit("s2_idx", word_index, 5); lit("s2_rc", retry_count, 3); lit("s2_ign", i2c_ignition, 0);

      // restart from FAIL
      mode = 5; clear_pulses(); pulse_start(); wait_end("s2r");
      lit("s2r_done", done, 1); lit("s2r_first", pulse_data.size() > 0 ? pulse_data[0] : 0, 16'h1E00);

      // finish never rises: timeouts on word 0
      mode = 3; clear_pulses(); pulse_start(); wait_end("s3");
      lit("s3_pulses", pulse_data.size(), 4);
      foreach (pulse_len[i]) lit($sformatf("s3_len%0d", i), pulse_len[i], TO);
      lit("s3_error", error, 1); lit("s3_idx", word_index, 0); lit("s3_rc", retry_count, 3);

      // reset during the attempt on word 2
      mode = 5; clear_pulses(); pulse_start();
      hit = 0;
      for (int c = 0; c < 20000; c++) begin
         if (i2c_ignition && i2c_data == 16'h0217) begin hit = 1; break; end
         @(negedge clk);
      end
      lit("s4_reached_word2", hit, 1);
      reset = 0; @(negedge clk); reset = 1;
      lit("s4_ign", i2c_ignition, 0); lit("s4_busy", busy, 0); lit("s4_data", i2c_data, 0);
      lit("s4_idx", word_index, 0); lit("s4_done", done, 0);

      // start held high for the whole run
      clear_pulses(); start = 1; wait_end("s4h");
      lit("s4h_pulses", pulse_data.size(), 11);
      lit("s4h_first", pulse_data.size() > 0 ? pulse_data[0] : 0, 16'h1E00);
      lit("s4h_done", done, 1);

      // start pulsed during an inter-attempt gap is ignored
      clear_pulses(); pulse_start();
      hit = 0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (pulse_data.size() >= 2 && !i2c_ignition && busy) begin hit = 1; break; end
      end
      lit("s5_in_gap", hit, 1);
      start = 1; repeat (3) @(negedge clk); start = 0;
      wait_end("s5");
      lit("s5_pulses", pulse_data.size(), 11);
      lit("s5_done", done, 1);

      // random engine behaviour: NACKs, timeouts, coincident finish, stale finish
      mode = 4;
      for (int r = 0; r < 3; r++) begin
         clear_pulses(); pulse_start(); wait_end($sformatf("s6_%0d", r));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
